// File: rtl/rvb_shifter_arb.sv
// rvb_shifter_arb: round-robin share of one shifter between two requesters; define RVB_SHIFTER_ARB_OVERLAP_EN to re-issue while a result is consumed
module rvb_shifter_arb #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [XLEN-1:0] req0_rs3,
  input  logic [6:0]      req0_insn,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [XLEN-1:0] req1_rs3,
  input  logic [6:0]      req1_insn,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_rd,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_rd,
  output logic            sh_din_valid,
  input  logic            sh_din_ready,
  output logic [XLEN-1:0] sh_rs1,
  output logic [XLEN-1:0] sh_rs2,
  output logic [XLEN-1:0] sh_rs3,
  output logic [6:0]      sh_insn,
  input  logic            sh_dout_valid,
  output logic            sh_dout_ready,
  input  logic [XLEN-1:0] sh_dout_rd
);
  typedef enum logic {IDLE, RESP} state_e;
  state_e state_q, state_d;
  logic last_q, last_d, owner_q, owner_d;
  logic [XLEN-1:0] res_q, res_d;
  logic grant0, grant1, issue, capture, consume, owner_ready, resp;
  assign resp = state_q == RESP;
  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;
`ifdef RVB_SHIFTER_ARB_OVERLAP_EN
  assign sh_dout_ready = !resp || owner_ready;
`else
  assign sh_dout_ready = !resp;
`endif
  assign grant0 = sh_dout_ready && req0_valid && (!req1_valid || last_q);
  assign grant1 = sh_dout_ready && req1_valid && (!req0_valid || !last_q);
  assign sh_din_valid = grant0 || grant1;
  assign sh_rs1 = grant0 ? req0_rs1 : grant1 ? req1_rs1 : '0;
  assign sh_rs2 = grant0 ? req0_rs2 : grant1 ? req1_rs2 : '0;
  assign sh_rs3 = grant0 ? req0_rs3 : grant1 ? req1_rs3 : '0;
  assign sh_insn = grant0 ? req0_insn : grant1 ? req1_insn : '0;
  assign req0_ready = grant0 && sh_din_ready;
  assign req1_ready = grant1 && sh_din_ready;
  assign issue = sh_din_valid && sh_din_ready;
  assign capture = sh_dout_valid && sh_dout_ready;
  assign consume = resp && owner_ready;
  assign rsp0_valid = resp && !owner_q;
  assign rsp1_valid = resp && owner_q;
  assign rsp0_rd = rsp0_valid ? res_q : '0;
  assign rsp1_rd = rsp1_valid ? res_q : '0;
  // the shifter answers in the issue cycle, so the current grant names the owner
  always_comb begin
    state_d = capture ? RESP : consume ? IDLE : state_q;
    last_d = issue ? grant1 : last_q;
    owner_d = capture ? grant1 : owner_q;
    res_d = capture ? sh_dout_rd : res_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      res_q <= res_d;
    end
endmodule

// File: tb/tb_rvb_shifter_arb.sv
// tb_rvb_shifter_arb: random and directed traffic against a queue-based model of the arbiter
module tb_rvb_shifter_arb;
  localparam int XLEN = 64;
`ifdef RVB_SHIFTER_ARB_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  typedef struct packed {logic own; logic [XLEN-1:0] rd;} res_t;
  logic clock = 1'b0, reset = 1'b0;
  logic rv[2], rr[2];
  logic [XLEN-1:0] a1[2], a2[2], a3[2];
  logic [6:0] ins[2];
  logic sh_din_ready;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, sh_din_valid, sh_dout_ready, sh_dout_valid;
  logic [XLEN-1:0] rsp0_rd, rsp1_rd, sh_rs1, sh_rs2, sh_rs3, sh_dout_rd;
  logic [6:0] sh_insn;
  int checks = 0, failures = 0;
  res_t q[$];
  int dlog[$];
  logic m_last = 1'b1;
  bit acc[2];
  always #5 clock = ~clock;
  function automatic logic [XLEN-1:0] f(input logic [XLEN-1:0] x, y, z, input logic [6:0] i);
    return (x << (y & 64'd63)) ^ z ^ {57'b0, i};
  endfunction
  assign sh_dout_valid = sh_din_valid && sh_din_ready;
  assign sh_dout_rd = f(sh_rs1, sh_rs2, sh_rs3, sh_insn);
  rvb_shifter_arb #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_rs1(a1[0]), .req0_rs2(a2[0]), .req0_rs3(a3[0]), .req0_insn(ins[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_rs1(a1[1]), .req1_rs2(a2[1]), .req1_rs3(a3[1]), .req1_insn(ins[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_rd(rsp0_rd),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_rd(rsp1_rd),
    .sh_din_valid(sh_din_valid), .sh_din_ready(sh_din_ready),
    .sh_rs1(sh_rs1), .sh_rs2(sh_rs2), .sh_rs3(sh_rs3), .sh_insn(sh_insn),
    .sh_dout_valid(sh_dout_valid), .sh_dout_ready(sh_dout_ready), .sh_dout_rd(sh_dout_rd)
  );
  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  // model: at most one result outstanding, grants follow the last-issued pointer
  always @(negedge clock) begin : model
    logic held, own, ordy, dr, any, g, gi;
    logic [XLEN-1:0] erd;
    if (reset) begin
      q.delete();
      m_last = 1'b1;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
    end else begin
      held = q.size() != 0;
      own = 1'b0;
      erd = '0;
      if (held) begin
        own = q[0].own;
        erd = q[0].rd;
      end
      ordy = own ? rr[1] : rr[0];
      dr = !held || (OVL && ordy);
      any = rv[0] || rv[1];
      g = dr && any;
      gi = (rv[0] && rv[1]) ? !m_last : rv[1];
      chk1("sh_dout_ready", sh_dout_ready, dr);
      chk1("sh_din_valid", sh_din_valid, g);
      chk1("req0_ready", req0_ready, g && !gi && sh_din_ready);
      chk1("req1_ready", req1_ready, g && gi && sh_din_ready);
      chk("sh_rs1", sh_rs1, g ? a1[gi] : '0);
      chk("sh_rs2", sh_rs2, g ? a2[gi] : '0);
      chk("sh_rs3", sh_rs3, g ? a3[gi] : '0);
      chk("sh_insn", 64'(sh_insn), g ? 64'(ins[gi]) : '0);
      chk1("rsp0_valid", rsp0_valid, held && !own);
      chk1("rsp1_valid", rsp1_valid, held && own);
      chk("rsp0_rd", rsp0_rd, (held && !own) ? erd : '0);
      chk("rsp1_rd", rsp1_rd, (held && own) ? erd : '0);
      acc[0] = rv[0] && req0_ready;
      acc[1] = rv[1] && req1_ready;
      if (acc[0]) dlog.push_back(0);
      if (acc[1]) dlog.push_back(1);
      if (held && ordy) void'(q.pop_front());
      if (g && sh_din_ready) begin
        q.push_back({gi, f(a1[gi], a2[gi], a3[gi], ins[gi])});
        m_last = gi;
      end
    end
  end
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic upd(int n, bit want);
    if (!rv[n] || acc[n]) begin
      rv[n] = want;
      a1[n] = {$urandom, $urandom};
      a2[n] = {$urandom, $urandom};
      a3[n] = {$urandom, $urandom};
      ins[n] = 7'($urandom);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask
  initial begin : main
    logic [XLEN-1:0] hold_rd;
    int sent[2];
    int nres, first, last;
    for (int n = 0; n < 2; n++) begin
      rv[n] = 1'b0; rr[n] = 1'b1; a1[n] = '0; a2[n] = '0; a3[n] = '0; ins[n] = '0;
    end
    sh_din_ready = 1'b1;
    #2 reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clock);
    chk1("reset rsp0_valid", rsp0_valid, 1'b0);
    chk1("reset rsp1_valid", rsp1_valid, 1'b0);
    chk1("reset sh_din_valid", sh_din_valid, 1'b0);
    chk1("reset sh_dout_ready", sh_dout_ready, 1'b1);
    cyc();
    a1[0] = 64'd1; a2[0] = 64'd4; a3[0] = '0; ins[0] = '0; rv[0] = 1'b1;
    @(negedge clock);
    chk1("sll req0_ready", req0_ready, 1'b1);
    cyc();
    rv[0] = 1'b0;
    @(negedge clock);
    chk1("sll rsp0_valid", rsp0_valid, 1'b1);
    chk("sll rsp0_rd", rsp0_rd, 64'h10);
    chk1("sll rsp1_valid", rsp1_valid, 1'b0);
    cyc();
    do_reset();
    dlog.delete();
    upd(0, 1'b1);
    upd(1, 1'b1);
    for (int c = 0; c < 40 && dlog.size() < 4; c++) begin
      cyc();
      upd(0, 1'b1);
      upd(1, 1'b1);
    end
    chk("rr grant count", 64'(dlog.size()), 64'd4);
    if (dlog.size() >= 4) begin
      chk("rr grant 0", 64'(dlog[0]), 64'd0);
      chk("rr grant 1", 64'(dlog[1]), 64'd1);
      chk("rr grant 2", 64'(dlog[2]), 64'd0);
      chk("rr grant 3", 64'(dlog[3]), 64'd1);
    end
    do_reset();
    rr[1] = 1'b0;
    upd(1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (acc[1]) break;
    end
    chk1("hold req1 issued", acc[1], 1'b1);
    rv[1] = 1'b0;
    upd(0, 1'b1);
    @(negedge clock);
    hold_rd = rsp1_rd;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk1("hold rsp1_valid", rsp1_valid, 1'b1);
      chk("hold rsp1_rd", rsp1_rd, hold_rd);
      chk1("hold req0_ready", req0_ready, 1'b0);
    end
    cyc();
    rr[1] = 1'b1;
    @(negedge clock);
    chk1("release req0_ready", req0_ready, OVL);
    cyc();
    @(negedge clock);
    chk1("after release req0_ready", req0_ready, 1'b1);
    cyc();
    rv[0] = 1'b0;
    do_reset();
    rr[0] = 1'b0;
    upd(0, 1'b1);
    cyc();
    rv[0] = 1'b0;
    @(negedge clock);
    chk1("pre-reset rsp0_valid", rsp0_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("async reset rsp0_valid", rsp0_valid, 1'b0);
    chk("async reset rsp0_rd", rsp0_rd, '0);
    repeat (2) cyc();
    reset = 1'b0;
    rr[0] = 1'b1;
    upd(0, 1'b1);
    upd(1, 1'b1);
    @(negedge clock);
    chk1("post-reset req0_ready", req0_ready, 1'b1);
    chk1("post-reset req1_ready", req1_ready, 1'b0);
    cyc();
    do_reset();
    sent[0] = 0;
    sent[1] = 0;
    upd(0, 1'b1);
    upd(1, 1'b1);
    nres = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 60 && nres < 8; c++) begin
      @(negedge clock);
      if (rsp0_valid || rsp1_valid) begin
        if (first < 0) first = c;
        last = c;
        nres++;
      end
      cyc();
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) sent[n]++;
        upd(n, sent[n] < 4);
      end
    end
    chk("stream results", 64'(nres), 64'd8);
    chk("stream span", 64'(last - first + 1), OVL ? 64'd8 : 64'd15);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int n = 0; n < 2; n++) begin
        if (rv[n] && !acc[n] && $urandom_range(0, 9) == 0) rv[n] = 1'b0;
        else upd(n, $urandom_range(0, 2) != 0);
        rr[n] = $urandom_range(0, 3) != 0;
      end
      sh_din_ready = $urandom_range(0, 3) != 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
